fc_irq_arbiter: RTL and testbench

Parametrised interrupt arbiter between the FC event unit and the FC core's vectored irq_x interface. It replaces the purely combinational id-to-one-hot expansion with registered state:
- pending capture, per line edge or level;
- a runtime enable mask;
- fixed or round-robin priority;
- a request/ack handshake that holds the chosen id stable until it is acknowledged.

---
 rtl/fc_irq_arbiter_if.sv | 28 ++
 rtl/fc_irq_arbiter.sv | 137 +++++++++++++
 tb/tb_fc_irq_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fc_irq_arbiter_if.sv
// Bus between the FC event unit / core and fc_irq_arbiter: raw lines, enable mask,
// request/ack handshake and status outputs.
interface fc_irq_arbiter_if #(
  parameter int N_IRQ    = 32,
  parameter int ID_WIDTH = $clog2(N_IRQ)
) ();
  logic [N_IRQ-1:0]    irq_i;
  logic [N_IRQ-1:0]    en_i;
  logic                irq_req_o;
  logic [ID_WIDTH-1:0] irq_id_o;
  logic [N_IRQ-1:0]    irq_x_o;
  logic                ack_i;
  logic [ID_WIDTH-1:0] ack_id_i;
  logic                ack_err_o;
  logic                wake_o;
  logic [N_IRQ-1:0]    pending_o;
  logic                timeout_o;

  modport slave (
    input  irq_i, en_i, ack_i, ack_id_i,
    output irq_req_o, irq_id_o, irq_x_o, ack_err_o, wake_o, pending_o, timeout_o
  );

  modport master (
    output irq_i, en_i, ack_i, ack_id_i,
    input  irq_req_o, irq_id_o, irq_x_o, ack_err_o, wake_o, pending_o, timeout_o
  );
endinterface

// File: rtl/fc_irq_arbiter.sv
// Registered interrupt arbiter: pending capture, enable mask, fixed/round-robin pick and
// a request/ack handshake. Define FC_IRQ_TIMEOUT_EN to withdraw requests left unacked.
module fc_irq_arbiter #(
  parameter int               N_IRQ          = 32,
  parameter int               ID_WIDTH       = $clog2(N_IRQ),
  parameter logic [N_IRQ-1:0] EDGE_MASK      = '0,
  parameter bit               RR_EN          = 1'b0,
  parameter int               TIMEOUT_CYCLES = 1024
) (
  input logic               clk_i,
  input logic               rst_i,
  fc_irq_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t              state_q, state_n;
  logic [N_IRQ-1:0]    irq_q, pending_q, pending_n, cand, clr;
  logic [ID_WIDTH-1:0] id_q, rr_ptr, sel_id;
  logic                sel_found, latch, leave_req, ack_match, ack_in_range;
  logic                tmo_expire, tmo_hit, ack_err_n, req;
  logic                ack_err_q, tmo_q, wake_q;
  int                  idx;

  function automatic logic [N_IRQ-1:0] onehot(input logic [ID_WIDTH-1:0] id);
    logic [N_IRQ-1:0] v;
    for (int i = 0; i < N_IRQ; i++) v[i] = (ID_WIDTH'(i) == id);
    return v;
  endfunction

  assign cand         = pending_q & bus.en_i;
  assign ack_in_range = int'(bus.ack_id_i) < N_IRQ;
  assign clr          = (bus.ack_i && ack_in_range) ? onehot(bus.ack_id_i) : '0;
  assign ack_match    = bus.ack_i && (state_q == REQ) && (bus.ack_id_i == id_q);

  // Edge lines: a new rising edge beats a same-cycle clear. Level lines mirror irq_i.
  always_comb begin
    pending_n = pending_q;
    for (int i = 0; i < N_IRQ; i++) begin
      if (EDGE_MASK[i]) pending_n[i] = (bus.irq_i[i] & ~irq_q[i]) | (pending_q[i] & ~clr[i]);
      else              pending_n[i] = bus.irq_i[i];
    end
  end

  // Scan from rr_ptr (round-robin) or from 0 (fixed); first candidate hit wins.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    idx       = 0;
    for (int k = 0; k < N_IRQ; k++) begin
      idx = RR_EN ? ((int'(rr_ptr) + k) % N_IRQ) : k;
      if (!sel_found && cand[ID_WIDTH'(idx)]) begin
        sel_found = 1'b1;
        sel_id    = ID_WIDTH'(idx);
      end
    end
  end

`ifdef FC_IRQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tmo_cnt;

  assign tmo_expire = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || state_q != REQ) tmo_cnt <= '0;
    else                         tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign tmo_expire = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    state_n   = state_q;
    latch     = 1'b0;
    tmo_hit   = 1'b0;
    ack_err_n = bus.ack_i && !ack_match;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_n = REQ;
          latch   = 1'b1;
        end
      end
      REQ: begin
        if (ack_match)             state_n = GAP;
        else if (!bus.en_i[id_q])  state_n = GAP;
        else if (tmo_expire) begin
          state_n = GAP;
          tmo_hit = 1'b1;
        end
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign leave_req = (state_q == REQ) && (state_n != REQ);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      irq_q     <= '0;
      pending_q <= '0;
      rr_ptr    <= '0;
      ack_err_q <= 1'b0;
      tmo_q     <= 1'b0;
      wake_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      irq_q     <= bus.irq_i;
      pending_q <= pending_n;
      ack_err_q <= ack_err_n;
      tmo_q     <= tmo_hit;
      wake_q    <= |cand;
      if (leave_req) begin
        if (int'(id_q) == N_IRQ - 1) rr_ptr <= '0;
        else                         rr_ptr <= id_q + 1'b1;
      end
    end
  end

  // The granted id is datapath state; it is only observed while in REQ.
  always_ff @(posedge clk_i) begin
    if (latch) id_q <= sel_id;
  end

  assign req           = (state_q == REQ);
  assign bus.irq_req_o = req;
  assign bus.irq_id_o  = req ? id_q : '0;
  assign bus.irq_x_o   = req ? onehot(id_q) : '0;
  assign bus.ack_err_o = ack_err_q;
  assign bus.wake_o    = wake_q;
  assign bus.pending_o = pending_q;
  assign bus.timeout_o = tmo_q;

endmodule

// File: tb/tb_fc_irq_arbiter.sv
// Scoreboard bench for fc_irq_arbiter: one fixed-priority instance (mostly edge lines,
// line 20 level) and one round-robin instance (all level lines).
module tb_fc_irq_arbiter;
  localparam int N = 32;
  localparam int W = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fc_irq_arbiter_if #(.N_IRQ(N), .ID_WIDTH(W)) b0 ();
  fc_irq_arbiter_if #(.N_IRQ(N), .ID_WIDTH(W)) b1 ();

  fc_irq_arbiter #(
    .N_IRQ(N), .ID_WIDTH(W), .EDGE_MASK(32'hFFEF_FFFF), .RR_EN(1'b0), .TIMEOUT_CYCLES(8)
  ) dut0 (.clk_i(clk), .rst_i(rst), .bus(b0.slave));

  fc_irq_arbiter #(
    .N_IRQ(N), .ID_WIDTH(W), .EDGE_MASK(32'h0000_0000), .RR_EN(1'b1), .TIMEOUT_CYCLES(8)
  ) dut1 (.clk_i(clk), .rst_i(rst), .bus(b1.slave));

  int n_assert = 0;
  int n_fail   = 0;
  int q0[$];
  int q1[$];
  int e0, e1;
  logic prev0 = 1'b0;
  logic prev1 = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack0(input int id);
    b0.ack_i    = 1'b1;
    b0.ack_id_i = W'(id);
    tick(1);
    b0.ack_i    = 1'b0;
  endtask

  // Each new request is matched against the oldest expected grant.
  always @(negedge clk) begin
    prev0 <= b0.irq_req_o;
    if (b0.irq_req_o && !prev0) begin
      if (q0.size() == 0) check("grant0_unexpected", q0.size(), 1);
      else begin
        e0 = q0.pop_front();
        check("grant0_id", b0.irq_id_o, e0);
        check("grant0_x", b0.irq_x_o, 64'(1) << e0);
      end
    end
  end

  always @(negedge clk) begin
    prev1 <= b1.irq_req_o;
    if (b1.irq_req_o && !prev1) begin
      if (q1.size() == 0) check("grant1_unexpected", q1.size(), 1);
      else begin
        e1 = q1.pop_front();
        check("grant1_id", b1.irq_id_o, e1);
        check("grant1_x", b1.irq_x_o, 64'(1) << e1);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    int rr_exp [4];
    int k;
    rr_exp = '{3, 9, 3, 9};
    rst = 1'b1;
    b0.irq_i = '0; b0.en_i = '1; b0.ack_i = 1'b0; b0.ack_id_i = '0;
    b1.irq_i = '0; b1.en_i = '1; b1.ack_i = 1'b0; b1.ack_id_i = '0;
    tick(3);
    check("rst_req", b0.irq_req_o, 0);
    check("rst_id", b0.irq_id_o, 0);
    check("rst_x", b0.irq_x_o, 0);
    check("rst_pending", b0.pending_o, 0);
    check("rst_wake", b0.wake_o, 0);
    check("rst_ack_err", b0.ack_err_o, 0);
    check("rst_timeout", b0.timeout_o, 0);
    check("rst_req_rr", b1.irq_req_o, 0);
    rst = 1'b0;
    tick(1);

    // single edge on line 5
    b0.irq_i[5] = 1'b1; q0.push_back(5);
    tick(1);
    check("t1_pend", b0.pending_o[5], 1);
    check("t1_req_early", b0.irq_req_o, 0);
    b0.irq_i[5] = 1'b0;
    tick(1);
    check("t1_req", b0.irq_req_o, 1);
    check("t1_wake", b0.wake_o, 1);
    ack0(5);
    check("t1_req_drop", b0.irq_req_o, 0);
    check("t1_pend_clr", b0.pending_o[5], 0);
    check("t1_no_err", b0.ack_err_o, 0);
    tick(2);

    // lines 3 and 9 together, fixed priority
    b0.irq_i[3] = 1'b1; b0.irq_i[9] = 1'b1; q0.push_back(3); q0.push_back(9);
    tick(1);
    b0.irq_i[3] = 1'b0; b0.irq_i[9] = 1'b0;
    tick(1);
    check("t2_req3", b0.irq_req_o, 1);
    ack0(3);
    check("t2_gap_a", b0.irq_req_o, 0);
    tick(1);
    check("t2_gap_b", b0.irq_req_o, 0);
    tick(1);
    check("t2_req9", b0.irq_req_o, 1);
    ack0(9);
    tick(2);
    check("t2_wake_idle", b0.wake_o, 0);

    // masking withdraws line 7 but keeps it pending
    b0.irq_i[7] = 1'b1; q0.push_back(7);
    tick(1);
    b0.irq_i[7] = 1'b0;
    tick(1);
    check("t3_req", b0.irq_req_o, 1);
    b0.en_i[7] = 1'b0;
    tick(1);
    check("t3_withdraw", b0.irq_req_o, 0);
    check("t3_pend_kept", b0.pending_o[7], 1);
    tick(2);
    check("t3_still_idle", b0.irq_req_o, 0);
    check("t3_wake_masked", b0.wake_o, 0);
    b0.en_i[7] = 1'b1; q0.push_back(7);
    tick(1);
    check("t3_rereq", b0.irq_req_o, 1);
    ack0(7);
    tick(2);

    // mismatched ack, then set-wins on the granted line
    b0.irq_i[4] = 1'b1; b0.irq_i[6] = 1'b1; q0.push_back(4);
    tick(1);
    b0.irq_i[4] = 1'b0; b0.irq_i[6] = 1'b0;
    tick(1);
    check("t4_req", b0.irq_req_o, 1);
    ack0(6);
    check("t4_err", b0.ack_err_o, 1);
    check("t4_pend6", b0.pending_o[6], 0);
    check("t4_hold", b0.irq_req_o, 1);
    check("t4_id", b0.irq_id_o, 4);
    tick(1);
    check("t4_err_once", b0.ack_err_o, 0);
    b0.irq_i[4] = 1'b1; q0.push_back(4);
    ack0(4);
    b0.irq_i[4] = 1'b0;
    check("t4_req_drop", b0.irq_req_o, 0);
    check("t4_set_wins", b0.pending_o[4], 1);
    check("t4_no_err", b0.ack_err_o, 0);
    tick(2);
    check("t4_rereq", b0.irq_req_o, 1);
    ack0(4);
    tick(2);

    ack0(10);
    check("idle_ack_err", b0.ack_err_o, 1);
    tick(1);

    // unacked request on line 12
    b0.irq_i[12] = 1'b1; q0.push_back(12);
    tick(1);
    b0.irq_i[12] = 1'b0;
    tick(1);
    check("t5_req", b0.irq_req_o, 1);
`ifdef FC_IRQ_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin
      tick(1);
      check("t5_hold", b0.irq_req_o, 1);
      check("t5_no_tmo_yet", b0.timeout_o, 0);
    end
    tick(1);
    check("t5_tmo", b0.timeout_o, 1);
    check("t5_tmo_drop", b0.irq_req_o, 0);
    check("t5_pend_kept", b0.pending_o[12], 1);
    q0.push_back(12);
    tick(1);
    check("t5_tmo_once", b0.timeout_o, 0);
    check("t5_gap", b0.irq_req_o, 0);
    tick(1);
    check("t5_rereq", b0.irq_req_o, 1);
`else
    for (int i = 0; i < 100; i++) begin
      tick(1);
      check("t5_hold", b0.irq_req_o, 1);
      check("t5_no_tmo", b0.timeout_o, 0);
    end
`endif
    ack0(12);
    tick(2);

    // reset while requesting on level line 20
    b0.irq_i[20] = 1'b1; q0.push_back(20);
    tick(2);
    check("t6_req", b0.irq_req_o, 1);
    rst = 1'b1;
    tick(1);
    check("t6_rst_req", b0.irq_req_o, 0);
    check("t6_rst_id", b0.irq_id_o, 0);
    check("t6_rst_x", b0.irq_x_o, 0);
    check("t6_rst_pending", b0.pending_o, 0);
    check("t6_rst_wake", b0.wake_o, 0);
    rst = 1'b0; q0.push_back(20);
    tick(1);
    check("t6_wait", b0.irq_req_o, 0);
    tick(1);
    check("t6_rereq", b0.irq_req_o, 1);
    b0.irq_i[20] = 1'b0;
    ack0(20);
    tick(2);

    // round-robin with levels 3 and 9 held
    b1.irq_i[3] = 1'b1; b1.irq_i[9] = 1'b1;
    for (int g = 0; g < 4; g++) q1.push_back(rr_exp[g]);
    for (int g = 0; g < 4; g++) begin
      k = 0;
      while (!b1.irq_req_o && k < 10) begin
        tick(1);
        k++;
      end
      check("rr_req", b1.irq_req_o, 1);
      check("rr_id", b1.irq_id_o, rr_exp[g]);
      b1.ack_i = 1'b1; b1.ack_id_i = W'(rr_exp[g]);
      if (g == 3) begin
        b1.irq_i[3] = 1'b0; b1.irq_i[9] = 1'b0;
      end
      tick(1);
      b1.ack_i = 1'b0;
      check("rr_drop", b1.irq_req_o, 0);
    end
    tick(4);
    check("sb_empty", q0.size() + q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
